// File: rtl/tx_data_buffer.sv
// rtl/tx_data_buffer.sv - byte FIFO between host writes and usb_tx reads, first-word fall-through head.
// Occupancy is the single source of truth for full/empty; pointers wrap naturally at power-of-two DEPTH.
module tx_data_buffer #(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       store_tx_data,
    input  logic [7:0] tx_data,
    input  logic       get_tx_packet_data,
    input  logic       clear,
    output logic [7:0] tx_packet_data,
    output logic [6:0] buffer_occupancy,
    output logic       full,
    output logic       empty,
    output logic       overflow_err,
    output logic       underflow_err
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [6:0] DEPTH_V = 7'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [6:0]    r_occ;
    logic          r_ovf;
    logic          r_unf;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_occ == DEPTH_V);
    assign w_empty = (r_occ == 7'd0);
    // A pop on a full buffer frees the slot the simultaneous write lands in.
    assign w_push  = store_tx_data & (~w_full | get_tx_packet_data);
    assign w_pop   = get_tx_packet_data & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem[r_wptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= 7'd0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else if (clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= 7'd0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + 7'd1;
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - 7'd1;
            end
            if (store_tx_data && w_full && !get_tx_packet_data) begin
                r_ovf <= 1'b1;
            end
            if (get_tx_packet_data && w_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign tx_packet_data   = w_empty ? 8'h00 : r_mem[r_rptr];
    assign buffer_occupancy = r_occ;
    assign full             = w_full;
    assign empty            = w_empty;
    assign overflow_err     = r_ovf;
    assign underflow_err    = r_unf;

endmodule

// File: tb/tb_tx_data_buffer.sv
// tb/tb_tx_data_buffer.sv - scoreboard bench for tx_data_buffer against a queue-based reference model.
module tb_tx_data_buffer;

    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       store_tx_data = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       get_tx_packet_data = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       full;
    logic       empty;
    logic       overflow_err;
    logic       underflow_err;

    always #5 clk = ~clk;

    tx_data_buffer #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .store_tx_data      (store_tx_data),
        .tx_data            (tx_data),
        .get_tx_packet_data (get_tx_packet_data),
        .clear              (clear),
        .tx_packet_data     (tx_packet_data),
        .buffer_occupancy   (buffer_occupancy),
        .full               (full),
        .empty              (empty),
        .overflow_err       (overflow_err),
        .underflow_err      (underflow_err)
    );

    logic [7:0] model_q[$];
    logic [7:0] exp_pop_q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        logic [7:0] head;
        head = (model_q.size() != 0) ? model_q[0] : 8'h00;
        chk({tag, "_occupancy"}, 32'(buffer_occupancy), 32'(model_q.size()));
        chk({tag, "_full"},      32'(full),  32'(model_q.size() == DEPTH));
        chk({tag, "_empty"},     32'(empty), 32'(model_q.size() == 0));
        chk({tag, "_overflow"},  32'(overflow_err),  32'(m_ovf));
        chk({tag, "_underflow"}, 32'(underflow_err), 32'(m_unf));
        chk({tag, "_head"},      32'(tx_packet_data), 32'(head));
    endtask

    // Entered and left at posedge+1; inputs are held across exactly one rising edge.
    task automatic cyc(input logic st, input logic [7:0] d, input logic gt, input logic cl, input string tag);
        int  n;
        logic push_ok, pop_ok;
        store_tx_data      = st;
        tx_data            = d;
        get_tx_packet_data = gt;
        clear              = cl;
        n       = model_q.size();
        push_ok = st && (n < DEPTH || gt);
        pop_ok  = gt && (n > 0);
        if (!cl && pop_ok) exp_pop_q.push_back(model_q[0]);
        @(posedge clk);
        #1;
        if (cl) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (gt && n == 0) m_unf = 1'b1;
            if (st && n == DEPTH && !gt) m_ovf = 1'b1;
            if (pop_ok) void'(model_q.pop_front());
            if (push_ok) model_q.push_back(d);
        end
        store_tx_data      = 1'b0;
        get_tx_packet_data = 1'b0;
        clear              = 1'b0;
        check_state(tag);
    endtask

    task automatic drain(input string tag);
        while (model_q.size() != 0) cyc(1'b0, 8'h00, 1'b1, 1'b0, tag);
    endtask

    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (n_rst && get_tx_packet_data && !empty && !clear) begin
                n_checks++;
                if (exp_pop_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_unexpected: got %0h expected no pop at %0t", tx_packet_data, $time);
                end else begin
                    e = exp_pop_q.pop_front();
                    if (tx_packet_data !== e) begin
                        n_fail++;
                        $display("FAIL pop_data: got %0h expected %0h at %0t", tx_packet_data, e, $time);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        #1 n_rst = 1'b0;
        #1 check_state("reset");
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;

        for (int i = 0; i < 64; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, "fill_seq");
        chk("fill_seq_full_head", 32'(tx_packet_data), 32'h00);
        drain("drain_seq");

        for (int i = 0; i < 64; i++) cyc(1'b1, 8'($urandom_range(0, 127)), 1'b0, 1'b0, "fill_rand");
        cyc(1'b1, 8'hAA, 1'b0, 1'b0, "overflow");
        chk("overflow_flag", 32'(overflow_err), 32'h1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, "full_push_pop");
        drain("drain_full");

        cyc(1'b0, 8'h00, 1'b1, 1'b0, "underflow");
        chk("underflow_flag", 32'(underflow_err), 32'h1);
        cyc(1'b1, 8'h5C, 1'b1, 1'b0, "empty_push_pop");
        chk("empty_push_pop_head", 32'(tx_packet_data), 32'h5C);
        drain("drain_5c");

        for (int i = 0; i < 10; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0, "pre_clear");
        cyc(1'b1, 8'h77, 1'b1, 1'b1, "clear");
        chk("clear_occupancy", 32'(buffer_occupancy), 32'h0);

        for (int i = 0; i < 40; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, "wrap_w40");
        for (int i = 0; i < 30; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "wrap_p30");
        for (int i = 0; i < 50; i++) cyc(1'b1, 8'(8'd40 + i), 1'b0, 1'b0, "wrap_w50");
        chk("wrap_occupancy", 32'(buffer_occupancy), 32'd60);
        drain("wrap_drain");

        for (int seg = 0; seg < 16; seg++) begin
            int wr = (seg % 2 == 1) ? 80 : 25;
            for (int i = 0; i < 150; i++) begin
                cyc($urandom_range(0, 99) < wr, 8'($urandom), $urandom_range(0, 99) < 50,
                    $urandom_range(0, 127) == 0, "random");
            end
        end
        drain("random_drain");

        for (int i = 0; i < 20; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0, "pre_reset");
        n_rst = 1'b0;
        #2;
        model_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_state("async_reset");
        #1 n_rst = 1'b1;
        cyc(1'b1, 8'h11, 1'b0, 1'b0, "post_reset");
        chk("post_reset_head", 32'(tx_packet_data), 32'h11);
        drain("final_drain");

        repeat (2) @(posedge clk);
        chk("pop_queue_drained", 32'(exp_pop_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
